// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the pipeline control slice: sequencer states, the
// per-cycle control bundle and the canned bundles the sequencer selects from.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HALT    = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  localparam logic [31:0] DISPLAY_CODE_DEF = 32'd34;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET  = '{pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b1,
                                    id_ex_en: 1'b0, id_ex_flush: 1'b1};
  localparam ctrl_t CTRL_FREEZE = '{pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0,
                                    id_ex_en: 1'b0, id_ex_flush: 1'b0};
  // Redirect squashes both younger stages; the fetch still advances to the target.
  localparam ctrl_t CTRL_REDIR  = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b1,
                                    id_ex_en: 1'b1, id_ex_flush: 1'b1};
  localparam ctrl_t CTRL_STALL  = '{pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0,
                                    id_ex_en: 1'b1, id_ex_flush: 1'b1};
  localparam ctrl_t CTRL_NORMAL = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0,
                                    id_ex_en: 1'b1, id_ex_flush: 1'b0};

endpackage

// File: rtl/go_edge_sync.sv
// Brings an asynchronous push-button level into clk and emits a one-cycle
// pulse on each synchronised rising edge.
module go_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic go_i,
  output logic go_rise_o
);

  // Fewer than two stages would leave a metastable sample visible downstream.
  localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], go_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign go_rise_o = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/halt sequencer for the 5-stage redirect pipeline: resolves EX
// redirects, ID load-use bubbles and the syscall halt/resume handshake.
module pipe_hazard_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter logic [31:0] DISPLAY_CODE = DISPLAY_CODE_DEF,
  parameter int          CNT_W        = 32,
  parameter int          SYNC_STAGES  = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             go,
  input  logic             load_use,
  input  logic             branch_ex,
  input  logic             jmp_ex,
  input  logic             syscall_ex,
  input  logic [31:0]      v0_ex,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             led_we,
  output logic             halted,
  output logic [CNT_W-1:0] cnt_cycle,
  output logic [CNT_W-1:0] cnt_branch,
  output logic [CNT_W-1:0] cnt_jmp,
  output logic [CNT_W-1:0] cnt_stall
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  ctrl_t            ctrl;
  logic             go_rise;
  logic             is_display;
  logic             halting_sys;
  logic             stall_sel;
  logic             active;
  logic [CNT_W-1:0] cnt_cycle_q, cnt_branch_q, cnt_jmp_q, cnt_stall_q;

  go_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_go_sync (
    .clk      (clk),
    .clr      (clr),
    .go_i     (go),
    .go_rise_o(go_rise)
  );

  assign is_display  = syscall_ex && (v0_ex == DISPLAY_CODE);
  // RELEASE retires the held syscall, so only RUN may start a new halt.
  assign halting_sys = (state_q == ST_RUN) && syscall_ex && (v0_ex != DISPLAY_CODE);
  assign active      = !clr && (state_q != ST_HALT);

  always_comb begin
    ctrl      = CTRL_NORMAL;
    state_d   = state_q;
    stall_sel = 1'b0;
    if (clr) begin
      ctrl    = CTRL_RESET;
      state_d = ST_RUN;
    end else if (state_q == ST_HALT) begin
      ctrl = CTRL_FREEZE;
      if (go_rise) begin
        state_d = ST_RELEASE;
      end
    end else if (halting_sys) begin
      ctrl    = CTRL_FREEZE;
      state_d = ST_HALT;
    end else begin
      state_d = ST_RUN;
      if (branch_ex || jmp_ex) begin
        ctrl = CTRL_REDIR;
      end else if (load_use) begin
        ctrl      = CTRL_STALL;
        stall_sel = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q      <= ST_RUN;
      cnt_cycle_q  <= '0;
      cnt_branch_q <= '0;
      cnt_jmp_q    <= '0;
      cnt_stall_q  <= '0;
    end else begin
      state_q <= state_d;
      if (active) begin
        cnt_cycle_q <= cnt_cycle_q + CNT_ONE;
      end
      if (active && branch_ex) begin
        cnt_branch_q <= cnt_branch_q + CNT_ONE;
      end
      if (active && jmp_ex) begin
        cnt_jmp_q <= cnt_jmp_q + CNT_ONE;
      end
      if (stall_sel) begin
        cnt_stall_q <= cnt_stall_q + CNT_ONE;
      end
    end
  end

  assign pc_en       = ctrl.pc_en;
  assign if_id_en    = ctrl.if_id_en;
  assign if_id_flush = ctrl.if_id_flush;
  assign id_ex_en    = ctrl.id_ex_en;
  assign id_ex_flush = ctrl.id_ex_flush;
  assign led_we      = active && is_display;
  assign halted      = !clr && (state_q == ST_HALT);
  assign cnt_cycle   = cnt_cycle_q;
  assign cnt_branch  = cnt_branch_q;
  assign cnt_jmp     = cnt_jmp_q;
  assign cnt_stall   = cnt_stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; control outputs are checked as the
// bundle {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, led_we, halted}.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 32;

  localparam logic [6:0] O_RST   = 7'b0010100;
  localparam logic [6:0] O_NORM  = 7'b1101000;
  localparam logic [6:0] O_FRZ   = 7'b0000000;
  localparam logic [6:0] O_HALT  = 7'b0000001;
  localparam logic [6:0] O_REDIR = 7'b1111100;
  localparam logic [6:0] O_STALL = 7'b0001100;
  localparam logic [6:0] O_DISP  = 7'b1101010;

  logic             clk = 1'b0;
  logic             clr, go, load_use, branch_ex, jmp_ex, syscall_ex;
  logic [31:0]      v0_ex;
  logic             pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, led_we, halted;
  logic [CNT_W-1:0] cnt_cycle, cnt_branch, cnt_jmp, cnt_stall;
  logic [6:0]       obs;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign obs = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, led_we, halted};

  pipe_hazard_ctrl #(
    .DISPLAY_CODE(32'd34),
    .CNT_W       (CNT_W),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .go         (go),
    .load_use   (load_use),
    .branch_ex  (branch_ex),
    .jmp_ex     (jmp_ex),
    .syscall_ex (syscall_ex),
    .v0_ex      (v0_ex),
    .pc_en      (pc_en),
    .if_id_en   (if_id_en),
    .if_id_flush(if_id_flush),
    .id_ex_en   (id_ex_en),
    .id_ex_flush(id_ex_flush),
    .led_we     (led_we),
    .halted     (halted),
    .cnt_cycle  (cnt_cycle),
    .cnt_branch (cnt_branch),
    .cnt_jmp    (cnt_jmp),
    .cnt_stall  (cnt_stall)
  );

  task automatic idle_inputs();
    load_use   = 1'b0;
    branch_ex  = 1'b0;
    jmp_ex     = 1'b0;
    syscall_ex = 1'b0;
    v0_ex      = 32'd0;
  endtask

  // Leaves the bench just after a negedge with clr low and a fresh reset applied.
  task automatic do_reset();
    @(negedge clk);
    clr = 1'b1;
    go  = 1'b0;
    idle_inputs();
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    go  = 1'b0;
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      branch_ex = (i == 1);
      #1;
      checks++;
      if (obs !== O_RST) begin
        failures++;
        $display("FAIL reset_ctrl[%0d] got=%b want=%b", i, obs, O_RST);
      end
    end
    @(negedge clk);
    clr = 1'b0;
    idle_inputs();
    #1;
    checks++;
    if ({cnt_cycle, cnt_branch, cnt_jmp, cnt_stall} !== '0) begin
      failures++;
      $display("FAIL reset_counters got=%0d/%0d/%0d/%0d want=0/0/0/0",
               cnt_cycle, cnt_branch, cnt_jmp, cnt_stall);
    end
    checks++;
    if (obs !== O_NORM) begin
      failures++;
      $display("FAIL reset_first_run got=%b want=%b", obs, O_NORM);
    end
    @(negedge clk);
    #1;
    checks++;
    if (cnt_cycle !== 32'd1) begin
      failures++;
      $display("FAIL reset_cycle_count got=%0d want=1", cnt_cycle);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    load_use = 1'b1;
    #1;
    checks++;
    if (obs !== O_STALL) begin
      failures++;
      $display("FAIL load_use_ctrl got=%b want=%b", obs, O_STALL);
    end
    @(negedge clk);
    load_use = 1'b0;
    #1;
    checks++;
    if (obs !== O_NORM) begin
      failures++;
      $display("FAIL load_use_after got=%b want=%b", obs, O_NORM);
    end
    checks++;
    if (cnt_stall !== 32'd1 || cnt_cycle !== 32'd1) begin
      failures++;
      $display("FAIL load_use_counts got=stall%0d/cyc%0d want=stall1/cyc1", cnt_stall, cnt_cycle);
    end
  endtask

  task automatic test_branch_load_use();
    do_reset();
    branch_ex = 1'b1;
    load_use  = 1'b1;
    #1;
    checks++;
    if (obs !== O_REDIR) begin
      failures++;
      $display("FAIL branch_lu_ctrl got=%b want=%b", obs, O_REDIR);
    end
    @(negedge clk);
    idle_inputs();
    jmp_ex = 1'b1;
    #1;
    checks++;
    if (obs !== O_REDIR) begin
      failures++;
      $display("FAIL jmp_ctrl got=%b want=%b", obs, O_REDIR);
    end
    checks++;
    if (cnt_branch !== 32'd1 || cnt_stall !== 32'd0) begin
      failures++;
      $display("FAIL branch_lu_counts got=br%0d/stall%0d want=br1/stall0", cnt_branch, cnt_stall);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (cnt_jmp !== 32'd1 || cnt_branch !== 32'd1 || cnt_cycle !== 32'd2) begin
      failures++;
      $display("FAIL jmp_counts got=jmp%0d/br%0d/cyc%0d want=jmp1/br1/cyc2",
               cnt_jmp, cnt_branch, cnt_cycle);
    end
  endtask

  task automatic test_halt_resume();
    do_reset();
    syscall_ex = 1'b1;
    v0_ex      = 32'd10;
    #1;
    checks++;
    if (obs !== O_FRZ) begin
      failures++;
      $display("FAIL halt_entry got=%b want=%b", obs, O_FRZ);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (obs !== O_HALT || cnt_cycle !== 32'd1) begin
        failures++;
        $display("FAIL halt_hold[%0d] got=%b cyc=%0d want=%b cyc=1", i, obs, cnt_cycle, O_HALT);
      end
    end
    // Go pulse: two synchroniser stages then one edge to enter RELEASE.
    @(negedge clk);
    go = 1'b1;
    #1;
    checks++;
    if (obs !== O_HALT) begin
      failures++;
      $display("FAIL halt_go_cycle0 got=%b want=%b", obs, O_HALT);
    end
    for (int i = 1; i < 3; i++) begin
      @(negedge clk);
      go = 1'b0;
      #1;
      checks++;
      if (obs !== O_HALT) begin
        failures++;
        $display("FAIL halt_go_cycle%0d got=%b want=%b", i, obs, O_HALT);
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (obs !== O_NORM || cnt_cycle !== 32'd1) begin
      failures++;
      $display("FAIL release_cycle got=%b cyc=%0d want=%b cyc=1", obs, cnt_cycle, O_NORM);
    end
    // A second halting syscall straight after RELEASE must halt again.
    @(negedge clk);
    #1;
    checks++;
    if (obs !== O_FRZ || cnt_cycle !== 32'd2) begin
      failures++;
      $display("FAIL back_to_back_entry got=%b cyc=%0d want=%b cyc=2", obs, cnt_cycle, O_FRZ);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (obs !== O_HALT) begin
      failures++;
      $display("FAIL back_to_back_halt got=%b want=%b", obs, O_HALT);
    end
    clr = 1'b1;
    #1;
    checks++;
    if (obs !== O_RST) begin
      failures++;
      $display("FAIL clr_over_halt got=%b want=%b", obs, O_RST);
    end
    @(negedge clk);
    clr = 1'b0;
    #1;
    checks++;
    if (obs !== O_NORM) begin
      failures++;
      $display("FAIL clr_exit_halt got=%b want=%b", obs, O_NORM);
    end
  endtask

  task automatic test_held_go();
    do_reset();
    go = 1'b1;
    repeat (3) @(negedge clk);
    syscall_ex = 1'b1;
    v0_ex      = 32'd10;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (obs !== O_HALT) begin
        failures++;
        $display("FAIL held_go_high[%0d] got=%b want=%b", i, obs, O_HALT);
      end
    end
    go = 1'b0;
    repeat (3) @(negedge clk);
    go = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (obs !== O_HALT) begin
        failures++;
        $display("FAIL held_go_repress[%0d] got=%b want=%b", i, obs, O_HALT);
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (obs !== O_NORM) begin
      failures++;
      $display("FAIL held_go_release got=%b want=%b", obs, O_NORM);
    end
    @(negedge clk);
    idle_inputs();
    go = 1'b0;
  endtask

  task automatic test_display();
    do_reset();
    syscall_ex = 1'b1;
    v0_ex      = 32'd34;
    #1;
    checks++;
    if (obs !== O_DISP) begin
      failures++;
      $display("FAIL display_strobe got=%b want=%b", obs, O_DISP);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (obs !== O_NORM || cnt_cycle !== 32'd1) begin
      failures++;
      $display("FAIL display_after got=%b cyc=%0d want=%b cyc=1", obs, cnt_cycle, O_NORM);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_load_use();
    test_halt_resume();
    test_held_go();
    test_display();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
